matrixify_loader: RTL and testbench

Byte-serial loader that assembles 16 incoming bytes into the 4x4 AES state matrix `matrix[row][col]`. The byte order is exactly the inverse of the dematrixify flattening. Byte k of the stream (k = 0 first) is the byte that dematrixify places at rawstring[127-8k:120-8k]. The block sits at the front of the cipher datapath, between the byte-wide input link and the round logic. It has a fill buffer and an output holding register, so the next block can load while the current matrix waits to be consumed.

---
 rtl/matrixify_loader_if.sv | 22 ++
 rtl/matrixify_loader.sv | 90 +++++++++
 tb/tb_matrixify_loader.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/matrixify_loader_if.sv
// Byte-stream and matrix handshake bundle for the AES state loader.
// The master drives bytes in and consumes matrices; the slave is the loader.
interface matrixify_loader_if;
  logic                  clear;
  logic [7:0]            byte_in;
  logic                  byte_valid;
  logic                  byte_ready;
  logic [3:0][3:0][7:0]  matrix;
  logic                  matrix_valid;
  logic                  matrix_ready;
  logic [7:0]            block_count;

  modport master (
    output clear, byte_in, byte_valid, matrix_ready,
    input  byte_ready, matrix, matrix_valid, block_count
  );

  modport slave (
    input  clear, byte_in, byte_valid, matrix_ready,
    output byte_ready, matrix, matrix_valid, block_count
  );
endinterface

// File: rtl/matrixify_loader.sv
// Assembles 16 serial bytes into the 4x4 AES state, column 3 first, row 3 first.
// A fill buffer plus an output holding register let the next block load while one waits.
module matrixify_loader (
  input  logic               clk_i,
  input  logic               rst_i,
  matrixify_loader_if.slave  ld_if
);

  logic [4:0]            cnt_q, cnt_d;
  logic [3:0][3:0][7:0]  fbuf_q, fbuf_d;
  logic [3:0][3:0][7:0]  matrix_q, matrix_d;
  logic                  matrix_valid_q, matrix_valid_d;
  logic [7:0]            block_count_q, block_count_d;

  logic                  full;
  logic                  accept;
  logic                  consume;
  logic                  transfer;
  logic [15:0]           cell_we;

  assign full     = (cnt_q == 5'd16);
  assign accept   = ld_if.byte_valid && ld_if.byte_ready && !ld_if.clear;
  assign consume  = matrix_valid_q && ld_if.matrix_ready;
  // clear outranks the hand-off, so a full buffer is dropped rather than delivered
  assign transfer = full && (!matrix_valid_q || ld_if.matrix_ready) && !ld_if.clear;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_cell_we
      assign cell_we[gi] = accept && (cnt_q == 5'(gi));
    end
  endgenerate

  always_comb begin
    fbuf_d = fbuf_q;
    for (int k = 0; k < 16; k++) begin
      if (cell_we[k]) begin
        fbuf_d[3 - (k % 4)][3 - (k / 4)] = ld_if.byte_in;
      end
    end
  end

  always_comb begin
    cnt_d          = cnt_q;
    matrix_d       = matrix_q;
    matrix_valid_d = matrix_valid_q;
    block_count_d  = block_count_q;

    if (ld_if.clear) begin
      cnt_d = 5'd0;
    end else if (transfer) begin
      cnt_d = 5'd0;
    end else if (accept) begin
      cnt_d = cnt_q + 5'd1;
    end

    if (transfer) begin
      matrix_d       = fbuf_q;
      matrix_valid_d = 1'b1;
    end else if (consume) begin
      matrix_valid_d = 1'b0;
    end

    if (consume) begin
      block_count_d = block_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q          <= 5'd0;
      fbuf_q         <= '0;
      matrix_q       <= '0;
      matrix_valid_q <= 1'b0;
      block_count_q  <= 8'd0;
    end else begin
      cnt_q          <= cnt_d;
      fbuf_q         <= fbuf_d;
      matrix_q       <= matrix_d;
      matrix_valid_q <= matrix_valid_d;
      block_count_q  <= block_count_d;
    end
  end

  assign ld_if.byte_ready   = !full && !rst_i;
  assign ld_if.matrix       = matrix_q;
  assign ld_if.matrix_valid = matrix_valid_q;
  assign ld_if.block_count  = block_count_q;

endmodule

// File: tb/tb_matrixify_loader.sv
// Randomized bench for matrixify_loader against a queue-based model of the loader.
module tb_matrixify_loader;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  matrixify_loader_if bus ();

  matrixify_loader dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .ld_if (bus.slave)
  );

  localparam logic [127:0] STREAM   = 128'h121b1904_637a1279_74620d15_77056458;
  localparam logic [127:0] EXP_BASE = 128'h12637477_1b7a6205_19120d64_04791558;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]            m_fill [$];
  logic [3:0][3:0][7:0]  m_mat;
  logic                  m_valid;
  logic [7:0]            m_count;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // byte k of a stream lands at row 3-k%4, column 3-k/4
  function automatic logic [127:0] to_matrix(input logic [127:0] s);
    logic [3:0][3:0][7:0] m;
    m = '0;
    for (int k = 0; k < 16; k++) m[3 - (k % 4)][3 - (k / 4)] = s[127 - 8*k -: 8];
    return m;
  endfunction

  function automatic logic [127:0] dematrixify(input logic [3:0][3:0][7:0] m);
    logic [127:0] raw;
    raw = '0;
    for (int k = 0; k < 16; k++) raw[127 - 8*k -: 8] = m[3 - (k % 4)][3 - (k / 4)];
    return raw;
  endfunction

  task automatic cycle(input bit v, input logic [7:0] b, input bit clr, input bit rdy, output bit acc);
    bit full, cons, xfer;
    logic [127:0] s;
    bus.byte_valid   = v;
    bus.byte_in      = b;
    bus.clear        = clr;
    bus.matrix_ready = rdy;
    #1;
    full = (m_fill.size() == 16);
    check("byte_ready", 128'(bus.byte_ready), 128'(!full));
    acc  = v && !full && !clr;
    cons = m_valid && rdy;
    xfer = full && (!m_valid || rdy) && !clr;
    if (cons) $display("consume block_count=%0d matrix=%h", m_count, m_mat);
    if (clr) begin
      m_fill.delete();
    end else if (xfer) begin
      s = '0;
      for (int k = 0; k < 16; k++) s[127 - 8*k -: 8] = m_fill[k];
      m_mat = to_matrix(s);
      m_fill.delete();
    end else if (acc) begin
      m_fill.push_back(b);
    end
    if (xfer) m_valid = 1'b1;
    else if (cons) m_valid = 1'b0;
    if (cons) m_count = m_count + 8'd1;
    @(posedge clk_i);
    #1;
    check("matrix_valid", 128'(bus.matrix_valid), 128'(m_valid));
    check("block_count", 128'(bus.block_count), 128'(m_count));
    check("matrix", bus.matrix, m_mat);
  endtask

  task automatic idle(input bit rdy);
    bit acc;
    cycle(1'b0, 8'h00, 1'b0, rdy, acc);
  endtask

  task automatic send_block(input logic [127:0] bits, input bit rdy, input bit sparse);
    int  k;
    int  budget;
    bit  acc;
    k = 0;
    budget = 400;
    while (k < 16 && budget > 0) begin
      if (sparse) begin
        repeat ($urandom_range(0, 3)) begin
          cycle(1'b0, 8'($urandom), 1'b0, rdy, acc);
          budget--;
        end
      end
      cycle(1'b1, bits[127 - 8*k -: 8], 1'b0, rdy, acc);
      if (acc) k++;
      budget--;
    end
    if (k < 16) check("send_timeout", 128'(k), 128'(16));
  endtask

  task automatic apply_reset();
    bus.byte_valid   = 1'b0;
    bus.byte_in      = 8'h00;
    bus.clear        = 1'b0;
    bus.matrix_ready = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    m_fill.delete();
    m_mat   = '0;
    m_valid = 1'b0;
    m_count = 8'd0;
    check("rst_byte_ready", 128'(bus.byte_ready), 128'(0));
    check("rst_valid", 128'(bus.matrix_valid), 128'(0));
    check("rst_matrix", bus.matrix, 128'(0));
    check("rst_count", 128'(bus.block_count), 128'(0));
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    #1;
    check("rst_release_ready", 128'(bus.byte_ready), 128'(1));
  endtask

  initial begin
    logic [127:0] s2;
    logic [127:0] rnd;
    bit acc;

    bus.byte_valid   = 1'b0;
    bus.byte_in      = 8'h00;
    bus.clear        = 1'b0;
    bus.matrix_ready = 1'b0;
    m_mat   = '0;
    m_valid = 1'b0;
    m_count = 8'd0;
    repeat (2) @(posedge clk_i);
    #1;
    apply_reset();

    // basic load with the output slot held back
    send_block(STREAM, 1'b0, 1'b0);
    check("lat_after_16th", 128'(bus.matrix_valid), 128'(0));
    idle(1'b0);
    check("lat_plus_one", 128'(bus.matrix_valid), 128'(1));
    check("basic_matrix", bus.matrix, EXP_BASE);
    check("dematrix_roundtrip", dematrixify(bus.matrix), STREAM);

    // second block loads behind the held one
    s2 = {$urandom, $urandom, $urandom, $urandom};
    send_block(s2, 1'b0, 1'b0);
    idle(1'b0);
    check("bp_ready_low", 128'(bus.byte_ready), 128'(0));
    check("bp_first_held", bus.matrix, EXP_BASE);
    idle(1'b1);
    check("bp_swap", bus.matrix, to_matrix(s2));
    check("bp_valid_stays", 128'(bus.matrix_valid), 128'(1));
    check("bp_ready_back", 128'(bus.byte_ready), 128'(1));
    idle(1'b1);

    // sparse byte_valid
    send_block(STREAM, 1'b0, 1'b1);
    idle(1'b0);
    check("sparse_matrix", bus.matrix, EXP_BASE);
    idle(1'b1);

    // clear mid-block, with a byte offered on the clear cycle
    for (int k = 0; k < 7; k++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0, acc);
    cycle(1'b1, 8'hAA, 1'b1, 1'b0, acc);
    send_block(STREAM, 1'b0, 1'b0);
    idle(1'b0);
    check("clear_matrix", bus.matrix, EXP_BASE);
    idle(1'b1);

    // clear while full suppresses the transfer
    send_block(s2, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, acc);
    check("clear_full_no_xfer", 128'(bus.matrix_valid), 128'(0));
    check("clear_full_ready", 128'(bus.byte_ready), 128'(1));
    repeat (3) idle(1'b0);
    check("clear_full_still_empty", 128'(bus.matrix_valid), 128'(0));

    // reset with a held matrix and a partial block
    send_block(STREAM, 1'b0, 1'b0);
    idle(1'b0);
    for (int k = 0; k < 9; k++) cycle(1'b1, s2[127 - 8*k -: 8], 1'b0, 1'b0, acc);
    apply_reset();
    send_block(STREAM, 1'b0, 1'b0);
    idle(1'b0);
    check("post_reset_matrix", bus.matrix, EXP_BASE);

    // 257 delivered and consumed blocks wrap the counter to 1
    apply_reset();
    for (int b = 0; b < 257; b++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      send_block(rnd, 1'b1, 1'($urandom_range(0, 1)));
    end
    repeat (3) idle(1'b1);
    check("wrap_count", 128'(bus.block_count), 128'(8'h01));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
